// File: rtl/if_queue_if.sv
// Fetch-side and decode-side signal bundle for if_queue.
// The master modport is the queue itself; the slave modport is memory plus decode.
interface if_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             req_valid;
  logic [31:0]      req_addr;
  logic             MIO_ready;
  logic [31:0]      inst_in;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_pred_taken;
  logic             id_stall;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] count;

  modport master (
    output req_valid, req_addr, out_valid, out_pc, out_inst, out_pred_taken, count,
    input  MIO_ready, inst_in, id_stall, redirect, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, out_valid, out_pc, out_inst, out_pred_taken, count,
    output MIO_ready, inst_in, id_stall, redirect, redirect_pc
  );
endinterface

// File: rtl/if_queue.sv
// Instruction fetch queue: fetches sequentially from fetch_pc and buffers
// {pc, inst} for decode. Define IFQ_JAL_PREDICT_EN to follow JAL targets at fetch.
module if_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  if_queue_if.master   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      next_pc;
  logic             full, push, pop;

  logic [31:0]      pc_mem_q   [DEPTH];
  logic [31:0]      inst_mem_q [DEPTH];

  logic             unused_rpc;
  assign unused_rpc = ^bus.redirect_pc[1:0];

  // A full queue refuses fetches even if decode pops this cycle.
  assign full          = (count_q == CNT_W'(DEPTH));
  assign bus.req_valid = rst_n & ~full & ~bus.redirect;
  assign bus.req_addr  = fetch_pc_q;
  assign push          = bus.req_valid & bus.MIO_ready;
  assign pop           = bus.out_valid & ~bus.id_stall & ~bus.redirect;

  assign bus.out_valid = (count_q != '0);
  assign bus.out_pc    = bus.out_valid ? pc_mem_q[head_q]   : '0;
  assign bus.out_inst  = bus.out_valid ? inst_mem_q[head_q] : '0;
  assign bus.count     = count_q;

`ifdef IFQ_JAL_PREDICT_EN
  logic        pred_mem_q [DEPTH];
  logic        is_jal;
  logic [31:0] jal_off;

  always_comb begin
    is_jal  = (bus.inst_in[6:0] == 7'b1101111);
    jal_off = {{11{bus.inst_in[31]}}, bus.inst_in[31], bus.inst_in[19:12],
               bus.inst_in[20], bus.inst_in[30:21], 1'b0};
    next_pc = is_jal ? fetch_pc_q + jal_off : fetch_pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (push) pred_mem_q[tail_q] <= is_jal;
  end

  assign bus.out_pred_taken = bus.out_valid ? pred_mem_q[head_q] : 1'b0;
`else
  assign next_pc            = fetch_pc_q + 32'd4;
  assign bus.out_pred_taken = 1'b0;
`endif

  // NOTE: storage has no reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]   <= fetch_pc_q;
      inst_mem_q[tail_q] <= bus.inst_in;
    end
  end

  // NOTE: every next-state signal gets its hold value first so no latch is inferred.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        tail_d     = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
        fetch_pc_d = next_pc;
      end
      if (pop) begin
        head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end
endmodule

// File: tb/tb_if_queue.sv
// Directed bench for if_queue (DEPTH=4, RESET_PC=0); memory returns {pc[24:0],7'h13}
// unless a JAL word is forced. Expectations follow IFQ_JAL_PREDICT_EN when defined.
module tb_if_queue;
  logic clk = 1'b0;
  logic rst_n;
  logic force_jal;
  int   n_checks = 0;
  int   n_fail   = 0;

  if_queue_if #(.DEPTH(4)) bus ();

  if_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.inst_in = force_jal ? 32'h0100_006F : {bus.req_addr[24:0], 7'h13};

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return {pc[24:0], 7'h13};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] jal_next;
    logic        jal_pred;
`ifdef IFQ_JAL_PREDICT_EN
    jal_next = 32'h30;
    jal_pred = 1'b1;
`else
    jal_next = 32'h24;
    jal_pred = 1'b0;
`endif
    rst_n = 1'b0; force_jal = 1'b0;
    bus.MIO_ready = 1'b0; bus.id_stall = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    #2;
    check("rst_count",     32'(bus.count),     32'd0);
    check("rst_req_valid", 32'(bus.req_valid), 32'd0);
    check("rst_req_addr",  bus.req_addr,       32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc",    bus.out_pc,         32'h0);
    check("rst_out_inst",  bus.out_inst,       32'h0);
    check("rst_out_pred",  32'(bus.out_pred_taken), 32'd0);

    // Streaming fetch after reset release
    @(negedge clk);
    rst_n = 1'b1; bus.MIO_ready = 1'b1;
    #1;
    check("seq_req_valid0", 32'(bus.req_valid), 32'd1);
    check("seq_req_addr0",  bus.req_addr,       32'h0);
    check("seq_out_valid0", 32'(bus.out_valid), 32'd0);
    step();
    check("seq_req_addr1",  bus.req_addr,       32'h4);
    check("seq_out_valid1", 32'(bus.out_valid), 32'd1);
    check("seq_out_pc1",    bus.out_pc,         32'h0);
    check("seq_out_inst1",  bus.out_inst,       exp_inst(32'h0));
    step();
    check("seq_req_addr2",  bus.req_addr,       32'h8);
    check("seq_count2",     32'(bus.count),     32'd1);
    check("seq_out_pc2",    bus.out_pc,         32'h4);
    step();
    check("seq_req_addr3",  bus.req_addr,       32'hC);
    check("seq_out_pc3",    bus.out_pc,         32'h8);

    // Fill under stall, then drain in order
    rst_n = 1'b0; bus.id_stall = 1'b1;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("full_count",     32'(bus.count),     32'd4);
    check("full_req_valid", 32'(bus.req_valid), 32'd0);
    check("full_req_addr",  bus.req_addr,       32'h10);
    step();
    check("full_hold_count", 32'(bus.count),    32'd4);
    check("full_hold_addr",  bus.req_addr,      32'h10);
    check("full_head_pc",    bus.out_pc,        32'h0);
    bus.id_stall = 1'b0; bus.MIO_ready = 1'b0;
    step();
    check("drain_pc1",    bus.out_pc,     32'h4);
    check("drain_inst1",  bus.out_inst,   exp_inst(32'h4));
    check("drain_count1", 32'(bus.count), 32'd3);
    step();
    check("drain_pc2",    bus.out_pc,     32'h8);
    step();
    check("drain_pc3",    bus.out_pc,     32'hC);
    check("drain_count3", 32'(bus.count), 32'd1);
    step();
    check("drain_empty",  32'(bus.out_valid), 32'd0);

    // Redirect with three entries queued
    bus.MIO_ready = 1'b1; bus.id_stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("pre_redir_count", 32'(bus.count), 32'd3);
    check("pre_redir_pc",    bus.out_pc,     32'h10);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h103;
    #1;
    check("redir_req_valid", 32'(bus.req_valid), 32'd0);
    step();
    bus.redirect = 1'b0; bus.id_stall = 1'b0;
    check("redir_count",     32'(bus.count),     32'd0);
    check("redir_out_valid", 32'(bus.out_valid), 32'd0);
    check("redir_req_addr",  bus.req_addr,       32'h100);
    step();
    check("refetch_valid",   32'(bus.out_valid), 32'd1);
    check("refetch_pc",      bus.out_pc,         32'h100);
    check("refetch_addr",    bus.req_addr,       32'h104);
    bus.MIO_ready = 1'b0;
    step();
    check("refetch_drain",   32'(bus.count),     32'd0);

    // MIO_ready toggling 1,0,1,0 under stall
    bus.id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.MIO_ready = (i % 2 == 0);
      step();
    end
    bus.MIO_ready = 1'b0;
    check("tog_count",    32'(bus.count), 32'd2);
    check("tog_req_addr", bus.req_addr,   32'h10C);
    check("tog_pc0",      bus.out_pc,     32'h104);
    bus.id_stall = 1'b0;
    step();
    check("tog_pc1",      bus.out_pc,     32'h108);
    check("tog_inst1",    bus.out_inst,   exp_inst(32'h108));
    step();
    check("tog_empty",    32'(bus.out_valid), 32'd0);

    // JAL at 0x20
    bus.redirect = 1'b1; bus.redirect_pc = 32'h20;
    step();
    bus.redirect = 1'b0; force_jal = 1'b1; bus.MIO_ready = 1'b1; bus.id_stall = 1'b1;
    step();
    force_jal = 1'b0;
    check("jal_req_addr", bus.req_addr,   jal_next);
    check("jal_out_pc",   bus.out_pc,     32'h20);
    check("jal_out_inst", bus.out_inst,   32'h0100_006F);
    check("jal_pred",     32'(bus.out_pred_taken), 32'(jal_pred));
    step();
    bus.MIO_ready = 1'b0;
    check("mid_count",    32'(bus.count), 32'd2);
    check("mid_req_addr", bus.req_addr,   jal_next + 32'd4);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("async_count",     32'(bus.count),     32'd0);
    check("async_req_addr",  bus.req_addr,       32'h0);
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_req_valid", 32'(bus.req_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.MIO_ready = 1'b1; bus.id_stall = 1'b0;
    step();
    check("post_rst_pc",    bus.out_pc,     32'h0);
    check("post_rst_count", 32'(bus.count), 32'd1);
    check("post_rst_addr",  bus.req_addr,   32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
